// File: rtl/freq_mult_pkg.sv
// freq_mult_pkg: shared sizes and FSM encoding for the frequency-multiplier datapath
package freq_mult_pkg;
  localparam int WIDTH = 8;
  localparam int MULT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/freq_mult_if.sv
// freq_mult_if: controller-to-generator request/result bundle
interface freq_mult_if;
  import freq_mult_pkg::*;
  logic start;
  logic [WIDTH-1:0] period_cnt;
  logic [MULT_W-1:0] mult;
  logic ready;
  logic busy;
  logic [WIDTH-1:0] quotient;
  logic err;
  logic out_freq;
  modport master (output start, period_cnt, mult, input ready, busy, quotient, err, out_freq);
  modport slave (input start, period_cnt, mult, output ready, busy, quotient, err, out_freq);
endinterface

// File: rtl/freq_mult_divider.sv
// freq_mult_divider: sequential restoring divider, one quotient bit per clock, MSB first
module freq_mult_divider #(
  parameter int WIDTH = 8,
  parameter int MULT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [MULT_W-1:0] divisor,
  output logic [WIDTH-1:0]  quot,
  output logic              done
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [MULT_W:0] rem, src_r, next_r;
  logic [MULT_W+1:0] sh;
  logic [WIDTH-1:0] src_q, next_q;
  logic [MULT_W-1:0] dvs, src_d;
  logic [CW-1:0] cnt;
  logic ge;
  // The load edge performs the first step from the raw inputs, so the last bit lands before done.
  always_comb begin
    src_r = load ? '0 : rem;
    src_q = load ? dividend : quot;
    src_d = load ? divisor : dvs;
    sh = {src_r, src_q[WIDTH-1]};
    ge = sh >= (MULT_W+2)'(src_d);
    next_r = (MULT_W+1)'(ge ? sh - (MULT_W+2)'(src_d) : sh);
    next_q = {src_q[WIDTH-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quot <= '0;
      dvs <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (load) begin
      rem <= next_r;
      quot <= next_q;
      dvs <= divisor;
      cnt <= CW'(1);
      done <= 1'b0;
    end else if (cnt != '0 && !done) begin
      rem <= next_r;
      quot <= next_q;
      cnt <= cnt + CW'(1);
      done <= cnt == CW'(WIDTH - 1);
    end
  end
endmodule

// File: rtl/freq_mult_generator.sv
// freq_mult_generator: captures period/mult, divides them, and emits a square wave of period quotient
module freq_mult_generator
  import freq_mult_pkg::*;
(
  input logic clk,
  input logic rst,
  freq_mult_if.slave bus
);
  state_t state;
  logic armed, accept, reload, div_done;
  logic [WIDTH-1:0] div_quot, count, half;
  assign accept = state == IDLE && bus.start && armed;
  assign reload = (accept && bus.mult == '0) || (state == DIVIDE && div_done);
  assign half = bus.quotient[WIDTH-1:1] == '0 ? WIDTH'(1) : {1'b0, bus.quotient[WIDTH-1:1]};
  freq_mult_divider #(.WIDTH(WIDTH), .MULT_W(MULT_W)) u_div (
    .clk(clk),
    .rst(rst),
    .load(accept && bus.mult != '0),
    .dividend(bus.period_cnt),
    .divisor(bus.mult),
    .quot(div_quot),
    .done(div_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b1;
      bus.ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
      bus.quotient <= '0;
      bus.out_freq <= 1'b0;
      count <= '0;
    end else begin
      armed <= bus.start ? armed && !accept : 1'b1;
      bus.ready <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus.err <= bus.mult == '0;
          if (bus.mult == '0) begin
            state <= DONE;
            bus.ready <= 1'b1;
            bus.quotient <= '0;
          end else begin
            state <= DIVIDE;
            bus.busy <= 1'b1;
          end
        end
        DIVIDE: if (div_done) begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.ready <= 1'b1;
          bus.quotient <= div_quot;
          bus.err <= div_quot == '0;
        end
        default: state <= IDLE;
      endcase
      // The wave keeps running on the old quotient until the result is loaded.
      if (reload || bus.quotient == '0) begin
        count <= '0;
        bus.out_freq <= 1'b0;
      end else if (count == half - WIDTH'(1)) begin
        count <= '0;
        bus.out_freq <= ~bus.out_freq;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end
endmodule
